// File: rtl/level_tally_if.sv
// Signal bundle between the level tally and its surroundings: event inputs in,
// window status and the scored difference out.
interface level_tally_if;
   logic       levelStart;
   logic       tick;
   logic       symbolShown;
   logic       userPress;
   logic       busy;
   logic       levelComplete;
   logic [4:0] difference;

   modport master (
      output levelStart, tick, symbolShown, userPress,
      input  busy, levelComplete, difference
   );

   modport slave (
      input  levelStart, tick, symbolShown, userPress,
      output busy, levelComplete, difference
   );
endinterface

// File: rtl/level_tally.sv
// Counts symbols shown and presses over a window of LEVEL_TICKS ticks and reports
// their saturated absolute difference with a one-cycle levelComplete strobe.
module level_tally #(
   parameter int LEVEL_TICKS = 5000,
   parameter int TICK_W      = 16
) (
   input  logic         Clk100M,
   input  logic         Reset,
   level_tally_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} state_t;

   localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(LEVEL_TICKS - 1);

   state_t            state, state_next;
   logic [4:0]        shown_cnt, press_cnt;
   logic [TICK_W-1:0] tick_cnt;
   logic              clear_cnt, count_en;

   function automatic logic [4:0] sat_inc(input logic [4:0] v, input logic en);
      if (en && (v != 5'd31)) return v + 5'd1;
      return v;
   endfunction

   function automatic logic [4:0] abs_diff(input logic [4:0] a, input logic [4:0] b);
      if (a >= b) return a - b;
      return b - a;
   endfunction

   always_ff @(posedge Clk100M) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   // A restart in RUN outranks expiry, so levelStart is tested first.
   always_comb begin
      state_next = state;
      clear_cnt  = 1'b0;
      count_en   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.levelStart) begin
               clear_cnt  = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (bus.levelStart) begin
               clear_cnt = 1'b1;
            end else begin
               count_en = 1'b1;
               if (bus.tick && (tick_cnt == LAST_TICK)) state_next = COMPARE;
            end
         end
         COMPARE: state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk100M) begin
      if (Reset || clear_cnt) begin
         shown_cnt <= '0;
         press_cnt <= '0;
         tick_cnt  <= '0;
      end else if (count_en) begin
         shown_cnt <= sat_inc(shown_cnt, bus.symbolShown);
         press_cnt <= sat_inc(press_cnt, bus.userPress);
         if (bus.tick) tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge Clk100M) begin
      if (Reset) begin
         bus.busy          <= 1'b0;
         bus.levelComplete <= 1'b0;
         bus.difference    <= '0;
      end else begin
         bus.busy          <= (state_next != IDLE);
         bus.levelComplete <= (state_next == DONE);
         if (state == COMPARE) bus.difference <= abs_diff(shown_cnt, press_cnt);
      end
   end

endmodule
